// File: rtl/hpm_detector.sv
// ----------------------------------------------------------------------------
// HpmDetector (module hpm_detector)
//
// Consumer side of the HPM tracer handshake. When the tracer raises
// EnableDetect with a frozen snapshot of the performance counters on HPMin,
// this block latches the snapshot and walks the counters one per cycle. Each
// counter is checked against a programmable upper bound. The scan produces an
// anomaly score, a per-counter hit vector and an alert flag. The block then
// raises EndDetect and holds it until the tracer drops EnableDetect.
//
// Ports:
//   clk_h        clock, all state updates on the rising edge
//   rst_h        asynchronous reset, active low
//   EnableDetect level request from the tracer, HPMin valid while high
//   HPMin        32 x 64-bit counter snapshot
//   EndDetect    completion flag, held until EnableDetect falls
//   cfg_we       threshold/mask write strobe (accepted in IDLE and DONE only)
//   cfg_idx      counter index being configured
//   cfg_thr      upper bound for counter cfg_idx
//   cfg_mask     1 = counter cfg_idx participates in scoring
//   busy         high while a captured snapshot is being scanned
//   score        number of masked-in counters above threshold (0..32)
//   alert        score >= ALERT_MIN, from the last completed scan
//   alert_vec    bit i = counter i exceeded its bound in the last completed scan
// ----------------------------------------------------------------------------
module hpm_detector #(
    parameter int NUM_CNT   = 32,
    parameter int ALERT_MIN = 1
) (
    input  logic              clk_h,
    input  logic              rst_h,
    input  logic              EnableDetect,
    input  logic [31:0][63:0] HPMin,
    output logic              EndDetect,
    input  logic              cfg_we,
    input  logic [4:0]        cfg_idx,
    input  logic [63:0]       cfg_thr,
    input  logic              cfg_mask,
    output logic              busy,
    output logic [5:0]        score,
    output logic              alert,
    output logic [31:0]       alert_vec
);

    localparam logic [4:0] LAST_IDX    = 5'(NUM_CNT - 1);
    localparam logic [5:0] NUM_CNT_W   = 6'(NUM_CNT);
    localparam logic [5:0] ALERT_MIN_W = 6'(ALERT_MIN);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    state_t             state;
    logic [31:0][63:0]  snap;
    logic [31:0][63:0]  thr;
    logic [31:0]        mask;
    logic [4:0]         idx;
    logic [5:0]         work_score;
    logic [31:0]        work_vec;

    logic               hit;
    logic [5:0]         next_score;
    logic [31:0]        next_vec;

    // Compare of the counter currently under the scan pointer, folded into
    // the running score/vector so the last cycle can commit directly.
    always_comb begin
        hit        = mask[idx] && (snap[idx] > thr[idx]);
        next_score = work_score + {5'd0, hit};
        next_vec   = work_vec | ({31'd0, hit} << idx);
    end

    // Snapshot register: loaded only on the capture edge, so HPMin is free to
    // move once the scan has started. No reset needed, it is never read
    // before being loaded.
    always_ff @(posedge clk_h) begin
        if (state == IDLE && EnableDetect) begin
            snap <= HPMin;
        end
    end

    // Threshold/mask storage. Writes are dropped while a scan is in flight so
    // the result always reflects one consistent configuration.
    always_ff @(posedge clk_h or negedge rst_h) begin
        if (!rst_h) begin
            thr  <= '1;
            mask <= '0;
        end else if (cfg_we && state != SCAN && {1'b0, cfg_idx} < NUM_CNT_W) begin
            thr[cfg_idx]  <= cfg_thr;
            mask[cfg_idx] <= cfg_mask;
        end
    end

    // Handshake/scan FSM with registered outputs. Results are only touched on
    // the final scan cycle, so an aborted scan leaves the previous result.
    always_ff @(posedge clk_h or negedge rst_h) begin
        if (!rst_h) begin
            state      <= IDLE;
            idx        <= '0;
            work_score <= '0;
            work_vec   <= '0;
            EndDetect  <= 1'b0;
            busy       <= 1'b0;
            score      <= '0;
            alert      <= 1'b0;
            alert_vec  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (EnableDetect) begin
                        idx        <= '0;
                        work_score <= '0;
                        work_vec   <= '0;
                        busy       <= 1'b1;
                        state      <= SCAN;
                    end
                end
                SCAN: begin
                    if (!EnableDetect) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (idx == LAST_IDX) begin
                        score     <= next_score;
                        alert_vec <= next_vec;
                        alert     <= (next_score >= ALERT_MIN_W);
                        EndDetect <= 1'b1;
                        busy      <= 1'b0;
                        state     <= DONE;
                    end else begin
                        work_score <= next_score;
                        work_vec   <= next_vec;
                        idx        <= idx + 5'd1;
                    end
                end
                DONE: begin
                    // Four-phase handshake: wait for the request to drop
                    // before a new capture can happen.
                    if (!EnableDetect) begin
                        EndDetect <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
